// File: rtl/alu_mul_seq.sv
// -----------------------------------------------------------------------------
// alu_mul_seq
//   Multi-cycle shift-and-add multiplier producing the low 32 bits of a 32x32
//   product. It owns no adder or shifter of its own: every arithmetic step is
//   issued to the shared single-cycle execute-stage ALU, one operation per
//   cycle (ADD to accumulate, SLL to shift the multiplicand).
//
// Ports
//   i_clk            clock, all state updates on the rising edge
//   i_reset          synchronous active-high reset
//   i_start          start request, only honoured while idle
//   i_op_a           multiplicand, captured on an accepted start
//   i_op_b           multiplier, captured on an accepted start
//   i_alu_data       combinational result returned by the shared ALU
//   o_alu_op_a       ALU operand A
//   o_alu_op_b       ALU operand B
//   o_alu_op         ALU opcode
//   o_alu_br_unsign  tied low
//   o_busy           high whenever the sequencer is not idle
//   o_done           one-cycle completion pulse
//   o_result         product[31:0], held from o_done until the next start
// -----------------------------------------------------------------------------
module alu_mul_seq #(
    parameter logic [3:0] OP_ADD     = 4'd0,
    parameter logic [3:0] OP_SLL     = 4'd2,
    parameter int         EARLY_TERM = 1
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_start,
    input  logic [31:0] i_op_a,
    input  logic [31:0] i_op_b,
    input  logic [31:0] i_alu_data,
    output logic [31:0] o_alu_op_a,
    output logic [31:0] o_alu_op_b,
    output logic [3:0]  o_alu_op,
    output logic        o_alu_br_unsign,
    output logic        o_busy,
    output logic        o_done,
    output logic [31:0] o_result
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ADD   = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic early_term = (EARLY_TERM != 0);

    state_t      state;
    state_t      state_next;
    logic [31:0] acc;
    logic [31:0] mcand;
    logic [31:0] mplier;
    logic [5:0]  cnt;
    logic [31:0] mplier_shr;

    // Multiplier as it will look after the current SHIFT step; the next-state
    // decision looks ahead at it so no idle cycle is spent re-examining bit 0.
    assign mplier_shr = {1'b0, mplier[31:1]};

    // State register
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (i_start) begin
                    if (early_term && (i_op_b == 32'd0)) begin
                        state_next = ST_DONE;
                    end else if (i_op_b[0]) begin
                        state_next = ST_ADD;
                    end else begin
                        state_next = ST_SHIFT;
                    end
                end
            end
            ST_ADD: begin
                state_next = ST_SHIFT;
            end
            ST_SHIFT: begin
                if ((cnt == 6'd31) || (early_term && (mplier_shr == 32'd0))) begin
                    state_next = ST_DONE;
                end else if (mplier_shr[0]) begin
                    state_next = ST_ADD;
                end else begin
                    state_next = ST_SHIFT;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Datapath registers. The result is captured on the edge that enters DONE
    // so it is already valid while o_done is high. DONE is only entered from
    // IDLE (zero multiplier, product 0) or from SHIFT (acc is final there,
    // since SHIFT never touches acc).
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            acc      <= 32'd0;
            mcand    <= 32'd0;
            mplier   <= 32'd0;
            cnt      <= 6'd0;
            o_result <= 32'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (i_start) begin
                        acc    <= 32'd0;
                        mcand  <= i_op_a;
                        mplier <= i_op_b;
                        cnt    <= 6'd0;
                        if (state_next == ST_DONE) begin
                            o_result <= 32'd0;
                        end
                    end
                end
                ST_ADD: begin
                    acc <= i_alu_data;
                end
                ST_SHIFT: begin
                    mcand  <= i_alu_data;
                    mplier <= mplier_shr;
                    cnt    <= cnt + 6'd1;
                    if (state_next == ST_DONE) begin
                        o_result <= acc;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Output decode
    always_comb begin
        o_alu_op        = OP_ADD;
        o_alu_op_a      = 32'd0;
        o_alu_op_b      = 32'd0;
        o_alu_br_unsign = 1'b0;
        o_busy          = (state != ST_IDLE);
        o_done          = (state == ST_DONE);
        case (state)
            ST_ADD: begin
                o_alu_op   = OP_ADD;
                o_alu_op_a = acc;
                o_alu_op_b = mcand;
            end
            ST_SHIFT: begin
                o_alu_op   = OP_SLL;
                o_alu_op_a = mcand;
                o_alu_op_b = 32'd1;
            end
            default: begin
            end
        endcase
    end

endmodule
